// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the multi-port integer register file.
package reg_file_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_e;

   localparam int XLEN_DEF     = 32;
   localparam int NUM_REGS_DEF = 32;

   typedef logic [$clog2(NUM_REGS_DEF)-1:0] rf_addr_t;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Clear-sweep controller: walks every register index once after reset or on
// request, then holds READY until the next reset or clear request.
module reg_file_clear_fsm
   import reg_file_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic          ready,
   output logic          clear_we,
   output logic [AW-1:0] clear_idx
);

   rf_state_e     state_reg;
   rf_state_e     state_next;
   logic [AW-1:0] idx_reg;
   logic [AW-1:0] idx_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= CLEAR;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         CLEAR: begin
            // A clear request mid-sweep restarts from the bottom.
            if (clr) begin
               idx_next = '0;
            end else if (idx_reg == AW'(NUM_REGS - 1)) begin
               state_next = READY;
               idx_next   = '0;
            end else begin
               idx_next = idx_reg + AW'(1);
            end
         end
         READY: begin
            if (clr) begin
               state_next = CLEAR;
               idx_next   = '0;
            end
         end
         default: begin
            state_next = CLEAR;
            idx_next   = '0;
         end
      endcase
   end

   assign ready     = (state_reg == READY);
   assign clear_we  = (state_reg == CLEAR);
   assign clear_idx = idx_reg;

endmodule

// File: rtl/register_file_mp_assert.sv
// Bindable checks: register 0 stays zero when hardwired, and nothing commits
// to the array while it is not ready.
module register_file_mp_assert #(
   parameter int XLEN     = 32,
   parameter int ZERO_REG = 1
) (
   input logic            clk,
   input logic            rst,
   input logic            ready,
   input logic [1:0]      wr_commit,
   input logic [XLEN-1:0] mem_zero
);

   a_zero_reg: assert property (@(posedge clk) disable iff (rst)
      ((ZERO_REG != 0) && ready) |-> (mem_zero == '0));

   a_no_write_when_busy: assert property (@(posedge clk) disable iff (rst)
      !ready |-> (wr_commit == 2'b00));

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational reads, two prioritised
// write ports (port 1 wins), optional same-cycle bypass and a clear sweep.
module register_file_mp
   import reg_file_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     clr,
   input  logic [1:0]                               wr_en,
   input  logic [1:0][$clog2(NUM_REGS)-1:0]         wr_reg,
   input  logic [1:0][XLEN-1:0]                     wr_data,
   input  logic [NUM_RD-1:0][$clog2(NUM_REGS)-1:0]  rd_reg,
   output logic [NUM_RD-1:0][XLEN-1:0]              rd_data,
   output logic                                     ready
);

   localparam int AW = $clog2(NUM_REGS);

   logic [XLEN-1:0] mem_reg [NUM_REGS];
   logic            clear_we;
   logic [AW-1:0]   clear_idx;
   logic [1:0]      wr_commit;

   reg_file_clear_fsm #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_clear_fsm (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .ready     (ready),
      .clear_we  (clear_we),
      .clear_idx (clear_idx)
   );

   // A write commits only in READY, never in a reset cycle, and never to a
   // hardwired register 0.  Bypass uses the same qualifier.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_wr
         assign wr_commit[gi] = wr_en[gi] & ready & ~rst &
                                ~((ZERO_REG != 0) && (wr_reg[gi] == '0));
      end
   endgenerate

   // Port 1 is applied last so it wins a same-register collision.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem_reg[clear_idx] <= '0;
      end else begin
         if (wr_commit[0]) begin
            mem_reg[wr_reg[0]] <= wr_data[0];
         end
         if (wr_commit[1]) begin
            mem_reg[wr_reg[1]] <= wr_data[1];
         end
      end
   end

   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [XLEN-1:0] rd_val;

         always_comb begin
            rd_val = '0;
            if (ready) begin
               rd_val = mem_reg[rd_reg[gi]];
               if (BYPASS != 0) begin
                  if (wr_commit[0] && (wr_reg[0] == rd_reg[gi])) begin
                     rd_val = wr_data[0];
                  end
                  if (wr_commit[1] && (wr_reg[1] == rd_reg[gi])) begin
                     rd_val = wr_data[1];
                  end
               end
               if ((ZERO_REG != 0) && (rd_reg[gi] == '0)) begin
                  rd_val = '0;
               end
            end
         end

         assign rd_data[gi] = rd_val;
      end
   endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: two configurations (bypass/2 reads, no-bypass/4 reads)
// driven in lockstep and compared against a behavioural register-file model.
bind register_file_mp register_file_mp_assert #(
   .XLEN     (XLEN),
   .ZERO_REG (ZERO_REG)
) u_assert (
   .clk       (clk),
   .rst       (rst),
   .ready     (ready),
   .wr_commit (wr_commit),
   .mem_zero  (mem_reg[0])
);

module tb_register_file_mp;

   localparam int NREG = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clr = 1'b0;
   logic [1:0]       wr_en = '0;
   logic [1:0][4:0]  wr_reg = '0;
   logic [1:0][31:0] wr_data = '0;
   logic [1:0][4:0]  rd_reg_a = '0;
   logic [1:0][31:0] rd_data_a;
   logic             ready_a;
   logic [3:0][4:0]  rd_reg_b = '0;
   logic [3:0][31:0] rd_data_b;
   logic             ready_b;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [NREG];
   int          m_left = NREG;

   always #5 clk = ~clk;

   register_file_mp #(
      .XLEN(32), .NUM_REGS(NREG), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
   ) dut_a (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_reg(wr_reg),
      .wr_data(wr_data), .rd_reg(rd_reg_a), .rd_data(rd_data_a), .ready(ready_a)
   );

   register_file_mp #(
      .XLEN(32), .NUM_REGS(NREG), .NUM_RD(4), .BYPASS(0), .ZERO_REG(1)
   ) dut_b (
      .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_reg(wr_reg),
      .wr_data(wr_data), .rd_reg(rd_reg_b), .rd_data(rd_data_b), .ready(ready_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Entering a clear wipes the whole file at once; reads are zero until the
   // countdown of NREG edges reaches zero, so the progressive sweep is invisible.
   function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit byp);
      if (m_left != 0 || addr == 5'd0) return 32'h0;
      if (byp && !rst) begin
         if (wr_en[1] && wr_reg[1] == addr) return wr_data[1];
         if (wr_en[0] && wr_reg[0] == addr) return wr_data[0];
      end
      return m_mem[addr];
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_left = NREG;
         foreach (m_mem[i]) m_mem[i] = '0;
      end else if (m_left == 0) begin
         for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_reg[p] != 5'd0) m_mem[wr_reg[p]] = wr_data[p];
         if (clr) begin
            m_left = NREG;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end else if (clr) begin
         m_left = NREG;
      end else begin
         m_left--;
      end
   endtask

   task automatic check_outputs();
      check("ready_a", {31'b0, ready_a}, {31'b0, m_left == 0});
      check("ready_b", {31'b0, ready_b}, {31'b0, m_left == 0});
      for (int i = 0; i < 2; i++)
         check($sformatf("rd_a%0d_r%0d", i, rd_reg_a[i]), rd_data_a[i], exp_read(rd_reg_a[i], 1'b1));
      for (int i = 0; i < 4; i++)
         check($sformatf("rd_b%0d_r%0d", i, rd_reg_b[i]), rd_data_b[i], exp_read(rd_reg_b[i], 1'b0));
   endtask

   // Inputs are set just after an edge; outputs are checked 1 ns later,
   // then the model advances on the next rising edge.
   task automatic tick();
      #1;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; clr = 1'b0; wr_en = '0;
   endtask

   task automatic count_until_ready(output int n);
      n = 0;
      while (!ready_a && n < 100) begin
         tick();
         n++;
      end
   endtask

   int n;
   int n_after;

   initial begin
      foreach (m_mem[i]) m_mem[i] = '0;
      @(posedge clk); #1;

      // Reset then sweep
      rst = 1'b1;
      tick(); tick();
      idle_inputs();
      count_until_ready(n);
      check("rst_sweep_len", n, 32);
      $display("txn reset sweep: ready after %0d cycles", n);

      // Preload reg 7 then reset: must read back zero
      wr_en = 2'b01; wr_reg[0] = 5'd7; wr_data[0] = 32'hDEADBEEF;
      tick();
      idle_inputs();
      rd_reg_a[0] = 5'd7; #1;
      check("preload_r7", rd_data_a[0], 32'hDEADBEEF);
      rst = 1'b1; tick(); rst = 1'b0;
      count_until_ready(n);
      check("rst2_sweep_len", n, 32);
      #1;
      check("r7_after_rst", rd_data_a[0], 32'h0);
      $display("txn preload r7 then reset: ready after %0d, r7=0x%08h", n, rd_data_a[0]);

      // Dual write to distinct registers
      wr_en = 2'b11; wr_reg[0] = 5'd3; wr_data[0] = 32'h11111111;
      wr_reg[1] = 5'd4; wr_data[1] = 32'h22222222;
      tick();
      idle_inputs();
      rd_reg_a[0] = 5'd3; rd_reg_a[1] = 5'd4; rd_reg_b[0] = 5'd3; rd_reg_b[1] = 5'd4; #1;
      check("dual_r3", rd_data_a[0], 32'h11111111);
      check("dual_r4", rd_data_a[1], 32'h22222222);
      check("dual_r4_b", rd_data_b[1], 32'h22222222);
      $display("txn dual write r3/r4: 0x%08h 0x%08h", rd_data_a[0], rd_data_a[1]);

      // Collision on reg 9: port 1 wins, bypassed same-cycle on dut_a only
      wr_en = 2'b11; wr_reg[0] = 5'd9; wr_data[0] = 32'hAAAA0000;
      wr_reg[1] = 5'd9; wr_data[1] = 32'h0000BBBB;
      rd_reg_a[0] = 5'd9; rd_reg_b[0] = 5'd9; #1;
      check("coll_bypass", rd_data_a[0], 32'h0000BBBB);
      check("coll_nobypass", rd_data_b[0], 32'h0);
      tick();
      idle_inputs(); #1;
      check("coll_after_a", rd_data_a[0], 32'h0000BBBB);
      check("coll_after_b", rd_data_b[0], 32'h0000BBBB);
      $display("txn collision r9: 0x%08h", rd_data_a[0]);

      // Register 0 is hardwired
      wr_en = 2'b11; wr_reg[0] = 5'd0; wr_data[0] = 32'h12345678;
      wr_reg[1] = 5'd0; wr_data[1] = 32'hFFFFFFFF;
      rd_reg_a[0] = 5'd0; rd_reg_b[0] = 5'd0; #1;
      check("r0_bypass", rd_data_a[0], 32'h0);
      tick();
      idle_inputs(); #1;
      check("r0_after_a", rd_data_a[0], 32'h0);
      check("r0_after_b", rd_data_b[0], 32'h0);
      $display("txn write r0: reads 0x%08h", rd_data_a[0]);

      // clr mid-operation, dropped write during sweep, rst at sweep cycle 10
      wr_en = 2'b01; wr_reg[0] = 5'd5; wr_data[0] = 32'h5;
      tick();
      idle_inputs();
      clr = 1'b1; tick(); clr = 1'b0;
      n = 0; n_after = 0;
      while (!ready_a && n < 200) begin
         wr_en = (n == 2) ? 2'b01 : 2'b00;
         wr_reg[0] = 5'd6; wr_data[0] = 32'h66666666;
         rst = (n == 9);
         tick();
         n_after = rst ? 0 : n_after + 1;
         n++;
      end
      idle_inputs();
      check("clr_sweep_len", n, 42);
      check("rst_restart_len", n_after, 32);
      rd_reg_a[0] = 5'd6; rd_reg_a[1] = 5'd5; #1;
      check("r6_dropped", rd_data_a[0], 32'h0);
      check("r5_cleared", rd_data_a[1], 32'h0);
      $display("txn clr with rst at cycle 10: low %0d cycles, %0d after rst", n, n_after);

      // Random soak
      for (int c = 0; c < 10000; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         clr = ($urandom_range(0, 199) == 0);
         wr_en = 2'($urandom);
         for (int p = 0; p < 2; p++) begin
            wr_reg[p] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            wr_data[p] = $urandom;
         end
         for (int i = 0; i < 2; i++)
            rd_reg_a[i] = ($urandom_range(0, 1) != 0) ? wr_reg[$urandom_range(0, 1)] : 5'($urandom);
         for (int i = 0; i < 4; i++)
            rd_reg_b[i] = ($urandom_range(0, 1) != 0) ? wr_reg[$urandom_range(0, 1)] : 5'($urandom);
         tick();
         if ((c + 1) % 1000 == 0)
            $display("txn soak block to cycle %0d: checks %0d errors %0d", c + 1, checks, errors);
      end
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file, successor to the single-write, dual-read `register_file` in the RISC-V datapath. It provides a configurable number of combinational read ports and two prioritised write ports for dual-issue and pipelined cores, with optional write-to-read bypass. A sequential clear sweep zeroes the array after reset or on request and reports availability through `ready`.

## Interface
- `XLEN`, 32, data width in bits
- `NUM_REGS`, 32, register count; power of two, at least 4
- `NUM_RD`, 2, read port count, 1–8
- `BYPASS`, 1, when 1 a same-cycle write is forwarded to matching reads
- `ZERO_REG`, 1, when 1 register 0 is hardwired to 0
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `clr`  in  1  synchronous request to re-run the clear sweep
- `wr_en`  in  [1:0]  per-write-port enable
- `wr_reg`  in  [1:0][$clog2(NUM_REGS)-1:0]  write addresses
- `wr_data`  in  [1:0][XLEN-1:0]  write data
- `rd_reg`  in  [NUM_RD-1:0][$clog2(NUM_REGS)-1:0]  read addresses
- `rd_data`  out  [NUM_RD-1:0][XLEN-1:0]  read data
- `ready`  out  1  high when the array is valid and accepting writes

## Operation
- FSM states: CLEAR and READY.
- `rst` forces CLEAR with `clear_idx`=0 on the next edge. `rst` wins over `clr`.
- CLEAR
  - Each cycle, write 0 to `mem[clear_idx]`, then increment `clear_idx`.
  - When `clear_idx`==NUM_REGS-1 is written, go to READY.
  - The sweep takes exactly NUM_REGS cycles.
- READY + `clr`: go to CLEAR with `clear_idx`=0. The `clr` cycle's writes are still committed.
- CLEAR + `clr`: restart the sweep at index 0.
- Writes in CLEAR are dropped silently. `rd_data` returns all zeros in CLEAR.
- Writes in READY
  - Port p commits `wr_data[p]` to `mem[wr_reg[p]]` when `wr_en[p]` is high.
  - If both ports target the same register, port 1 wins.
  - If ZERO_REG=1, writes to register 0 are discarded.
- Reads are combinational: `rd_data[i]` = `mem[rd_reg[i]]`.
  - If ZERO_REG=1, address 0 always reads 0, regardless of bypass.
- Bypass (BYPASS=1, READY only)
  - If an enabled write port matches `rd_reg[i]`, that write's data is returned in the same cycle.
  - If both write ports match, port 1's data is returned.
  - BYPASS=0: read-before-write; new data is visible the cycle after the edge.

## Timing
- Reset values:
  - `ready`=0 from the edge where `rst` is sampled until the sweep completes.
  - `rd_data`=0 throughout that period.
  - `ready` rises NUM_REGS cycles after `rst` deasserts.
- Read latency is 0 cycles (combinational).
- Write latency is 1 edge without bypass, 0 cycles with bypass.
- `ready` is a registered output (state==READY). No combinational path from `clr` or `rst` to `ready`.
- `rst` asserted mid-sweep restarts the sweep at index 0. The final count is NUM_REGS cycles after the last `rst`.

## Structure
- Package `reg_file_pkg`:
  - `rf_state_e` {CLEAR, READY}
  - default constants XLEN_DEF=32, NUM_REGS_DEF=32
  - `rf_addr_t` typedef for the default configuration
- Sub-module `reg_file_clear_fsm`:
  - owns the state register and `clear_idx` counter
  - outputs `ready`, `clear_we` and `clear_idx`
- Top level holds the storage array, write-port priority, bypass muxes and zero-register masking.
- Bindable assertions module `register_file_mp_assert` checks:
  - `mem[0]`==0 when ZERO_REG=1
  - no write commits while `ready`=0

## Test plan
- Reset then clear: preload reg 7=0xDEADBEEF, pulse `rst`.
  - `ready` stays 0 for 32 cycles, then goes to 1.
  - A read of reg 7 returns 0x00000000.
- Dual write, distinct registers: port0 writes reg 3=0x11111111, port1 writes reg 4=0x22222222.
  - Next cycle, `rd_reg`={3,4} returns {0x11111111, 0x22222222}.
- Write collision: both ports write reg 9, port0 0xAAAA0000, port1 0x0000BBBB.
  - Reg 9 reads 0x0000BBBB.
  - With BYPASS=1, same-cycle reads of reg 9 return 0x0000BBBB.
- Register 0: port1 writes reg 0=0xFFFFFFFF with both enables high.
  - All reads of reg 0 return 0, including the same-cycle bypass read.
- `clr` mid-operation: write reg 5=0x5, assert `clr` for 1 cycle.
  - `ready`=0 for the next 32 cycles.
  - A write to reg 6 during the sweep is dropped; reg 6 reads 0 afterwards.
  - `rst` at sweep cycle 10 restarts the 32-cycle count.
- Random soak: 10000 cycles of random enables, addresses, data and reads, checked against a reference model with port-1 priority. Repeat with NUM_RD=4 and BYPASS=0.
